udp_frame_ring_buffer: RTL and testbench

- Single-clock, parametrised multi-slot frame buffer between the AD sample stream and the UDP/GMII transmit engine.
- Collects fixed-length frames into a ring of 2^SLOT_AW slots.
- Hands each completed frame to the TX engine with a start pulse and a per-read data stream.
- Successor to the two-clock single-frame buffer. Adds:
  - configurable data width, frame length and slot depth;
  - whole-frame drop on overflow with a drop counter;
  - an occupancy status output.

---
 rtl/udp_frame_ring_buffer.sv | 195 +++++++++++++++++++
 tb/tb_udp_frame_ring_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_frame_ring_buffer.sv
// udp_frame_ring_buffer
//   Multi-slot frame buffer that sits between the AD sample stream and the
//   UDP/GMII transmit engine. Fixed-length frames are collected into a ring
//   of 2^SLOT_AW slots. Each completed frame is handed to the TX engine with
//   a one-cycle start pulse, and the engine then pulls the words out one at
//   a time. If a frame starts while every slot is still occupied, the whole
//   frame is dropped and counted.
//
// Ports:
//   clk            system clock for both the write and the read side
//   rst_n          synchronous reset, active low
//   wr_data/wr_en  sample word and its valid strobe
//   frame_tx_start one-cycle pulse: a committed frame is ready (tx_start_en)
//   frame_tx_done  TX engine finished with the current frame (tx_done)
//   rd_en          word request from the TX engine (tx_req)
//   rd_data        frame word, valid the cycle after rd_en (tx_data)
//   rd_byte_num    constant frame size in bytes
//   occupancy      committed slots not yet released
//   overflow       one-cycle pulse, raised the cycle after word 0 of a
//                  dropped frame is taken
//   drop_cnt       dropped-frame count, saturating
//
// Handshake: there is no back-pressure on either side. wr_en is a plain
//   valid strobe and every asserted cycle consumes one word. rd_en is only
//   honoured in the SEND state: each honoured rd_en returns one word on
//   rd_data one cycle later, and rd_data holds its value otherwise.
module udp_frame_ring_buffer #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 1024,
  parameter int SLOT_AW   = 1,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_en,
  output logic                frame_tx_start,
  input  logic                frame_tx_done,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic [LEN_W-1:0]    rd_byte_num,
  output logic [SLOT_AW:0]    occupancy,
  output logic                overflow,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam int SLOTS     = 1 << SLOT_AW;
  localparam int DEPTH     = SLOTS * FRAME_LEN;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int BYTE_NUM  = FRAME_LEN * DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [SLOT_AW:0] FULL_OCC = (SLOT_AW + 1)'(SLOTS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_SEND      = 2'd2,
    S_WAIT_DONE = 2'd3
  } rd_state_t;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   wr_idx;
  logic [SLOT_AW-1:0] wr_slot;
  logic               drop_q;
  logic [IDX_W-1:0]   rd_idx;
  logic [SLOT_AW-1:0] rd_slot;

  // Read FSM state; kept as a plain named signal so checkers can bind to it.
  rd_state_t          rd_state, rd_state_nxt;

  logic               wr_first, accept_now, wr_drop, commit;
  logic               rd_fire, release_slot;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;

  assign rd_byte_num = LEN_W'(BYTE_NUM);

  // ---------------------------------------------------------------- write side
  // The accept decision is made on word 0 against the registered occupancy,
  // so a release landing in the same cycle does not free a slot in time.
  assign wr_first   = wr_en && (wr_idx == '0);
  assign accept_now = (occupancy < FULL_OCC);
  // Word 0 uses the fresh decision; later words use the one held in drop_q.
  assign wr_drop    = wr_first ? !accept_now : drop_q;
  assign commit     = wr_en && !wr_drop && (wr_idx == LAST_IDX);
  assign wr_addr    = ADDR_W'(wr_slot) * ADDR_W'(FRAME_LEN) + ADDR_W'(wr_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      wr_slot  <= '0;
      drop_q   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= wr_first && !accept_now;
      if (wr_en) begin
        // Dropped words still advance the index so frame alignment is kept.
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
      end
      if (wr_first) begin
        drop_q <= !accept_now;
      end
      if (commit) begin
        wr_slot <= wr_slot + SLOT_AW'(1);
      end
      if (wr_first && !accept_now && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_drop) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= S_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      S_IDLE:      if (occupancy != '0) rd_state_nxt = S_START;
      S_START:     rd_state_nxt = S_SEND;
      // A done while sending aborts the frame; the rest of it is discarded.
      S_SEND: begin
        if (frame_tx_done) begin
          rd_state_nxt = S_IDLE;
        end else if (rd_en && (rd_idx == LAST_IDX)) begin
          rd_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (frame_tx_done) rd_state_nxt = S_IDLE;
      default:     rd_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    frame_tx_start = (rd_state == S_START);
    rd_fire        = (rd_state == S_SEND) && rd_en && !frame_tx_done;
    release_slot   = frame_tx_done &&
                     ((rd_state == S_SEND) || (rd_state == S_WAIT_DONE));
  end

  // ------------------------------------------------------------ read datapath
  assign rd_addr = ADDR_W'(rd_slot) * ADDR_W'(FRAME_LEN) + ADDR_W'(rd_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_idx  <= '0;
      rd_slot <= '0;
    end else begin
      if (rd_state == S_START) begin
        rd_idx <= '0;
      end else if (rd_fire) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
      end
      if (release_slot) begin
        rd_slot <= rd_slot + SLOT_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_fire) begin
      rd_data <= mem[rd_addr];
    end
  end

  // A commit and a release in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({commit, release_slot})
        2'b10:   occupancy <= occupancy + (SLOT_AW + 1)'(1);
        2'b01:   occupancy <= occupancy - (SLOT_AW + 1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_frame_ring_buffer.sv
// tb_udp_frame_ring_buffer
//   Self-checking bench for udp_frame_ring_buffer with FRAME_LEN=16,
//   SLOT_AW=1, DATA_W=8. Words of every frame expected to be accepted are
//   pushed to exp_q as they are written and popped as rd_data returns them.
module tb_udp_frame_ring_buffer;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 16;
  localparam int SLOT_AW   = 1;
  localparam int LEN_W     = 16;
  localparam int CNT_W     = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                frame_tx_start;
  logic                frame_tx_done;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_data;
  logic [LEN_W-1:0]    rd_byte_num;
  logic [SLOT_AW:0]    occupancy;
  logic                overflow;
  logic [CNT_W-1:0]    drop_cnt;

  logic [DATA_W-1:0]   exp_q[$];
  int                  n_checks = 0;
  int                  n_pass   = 0;
  int                  start_cnt = 0;
  int                  ovf_cnt   = 0;
  int                  snap;

  udp_frame_ring_buffer #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .SLOT_AW   (SLOT_AW),
    .LEN_W     (LEN_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .frame_tx_start (frame_tx_start),
    .frame_tx_done  (frame_tx_done),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_byte_num    (rd_byte_num),
    .occupancy      (occupancy),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
  );

  // ------------------------------------------------------ clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_tx_start === 1'b1) start_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  // ---------------------------------------------------------------- checker
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // ----------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [DATA_W-1:0] base, input bit accept);
    for (int i = 0; i < FRAME_LEN; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DATA_W'(i);
      if (accept) exp_q.push_back(base + DATA_W'(i));
      tick();
      if (i == 0) check_val("ovf_word0", overflow, !accept);
    end
    wr_en = 1'b0;
  endtask

  task automatic read_words(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: scoreboard empty, got=0x%0h expected=none", tag, rd_data);
      end else begin
        check_val(tag, rd_data, exp_q.pop_front());
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic pulse_done();
    frame_tx_done = 1'b1;
    tick();
    frame_tx_done = 1'b0;
  endtask

  // Waits for the start pulse, then one more cycle so the FSM is in SEND.
  task automatic wait_start(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (frame_tx_start === 1'b1) seen = 1'b1;
    end
    check_val(tag, seen, 1'b1);
    if (seen) tick();
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    rst_n         = 1'b0;
    wr_en         = 1'b0;
    wr_data       = '0;
    rd_en         = 1'b0;
    frame_tx_done = 1'b0;
    repeat (3) tick();
    check_val("rst_start", frame_tx_start, 1'b0);
    check_val("rst_ovf", overflow, 1'b0);
    check_val("rst_rd_data", rd_data, 8'h00);
    check_val("rst_occ", occupancy, 2'd0);
    check_val("rst_drop_cnt", drop_cnt, 16'd0);
    check_val("byte_num", rd_byte_num, 16'd16);
    rst_n = 1'b1;
    tick();

    // Single frame
    write_frame(8'h00, 1'b1);
    check_val("t1_occ_commit", occupancy, 2'd1);
    wait_start("t1_start", 2);
    read_words(FRAME_LEN, "t1_rd");
    check_val("t1_start_cnt", start_cnt, 1);
    pulse_done();
    check_val("t1_occ_release", occupancy, 2'd0);
    check_val("t1_byte_num", rd_byte_num, 16'd16);

    // Ping-pong: B is written while A is being read
    snap = start_cnt;
    write_frame(8'h10, 1'b1);
    wait_start("t2_start_a", 4);
    fork
      read_words(FRAME_LEN, "t2_rd_a");
      write_frame(8'h20, 1'b1);
    join
    check_val("t2_occ_two", occupancy, 2'd2);
    pulse_done();
    wait_start("t2_start_b", 4);
    read_words(FRAME_LEN, "t2_rd_b");
    pulse_done();
    check_val("t2_start_pulses", start_cnt - snap, 2);
    check_val("t2_no_ovf", ovf_cnt, 0);
    check_val("t2_occ_empty", occupancy, 2'd0);

    // Overflow: three frames without reading, the third is dropped
    write_frame(8'h30, 1'b1);
    write_frame(8'h50, 1'b1);
    write_frame(8'h70, 1'b0);
    check_val("t3_occ_full", occupancy, 2'd2);
    check_val("t3_drop_cnt", drop_cnt, 16'd1);
    check_val("t3_ovf_pulses", ovf_cnt, 1);
    read_words(FRAME_LEN, "t3_rd1");
    pulse_done();
    wait_start("t3_start2", 4);
    read_words(FRAME_LEN, "t3_rd2");
    pulse_done();
    check_val("t3_occ_empty", occupancy, 2'd0);
    write_frame(8'h40, 1'b1);
    wait_start("t3_start4", 4);
    read_words(FRAME_LEN, "t3_rd4");
    pulse_done();
    check_val("t3_drop_cnt_hold", drop_cnt, 16'd1);

    // Simultaneous commit and release
    write_frame(8'h80, 1'b1);
    wait_start("t4_start", 4);
    read_words(FRAME_LEN, "t4_rd");
    check_val("t4_occ_wait", occupancy, 2'd1);
    fork
      write_frame(8'h90, 1'b1);
      begin
        repeat (FRAME_LEN - 1) tick();
        check_val("t4_occ_before", occupancy, 2'd1);
        frame_tx_done = 1'b1;
        tick();
        frame_tx_done = 1'b0;
      end
    join
    check_val("t4_occ_same", occupancy, 2'd1);
    wait_start("t4_next_start", 4);
    read_words(FRAME_LEN, "t4_rd_next");
    pulse_done();
    check_val("t4_occ_empty", occupancy, 2'd0);

    // Abort after 5 reads, next frame starts at word 0
    write_frame(8'hA0, 1'b1);
    wait_start("t5_start_abort", 4);
    read_words(5, "t5_rd_abort");
    pulse_done();
    repeat (FRAME_LEN - 5) void'(exp_q.pop_front());
    check_val("t5_occ_abort", occupancy, 2'd0);
    write_frame(8'hB0, 1'b1);
    wait_start("t5_start_after", 4);
    read_words(FRAME_LEN, "t5_rd_after");
    pulse_done();

    // Over-read: 20 requests on a 16-word frame
    write_frame(8'h00, 1'b1);
    wait_start("t5_start_over", 4);
    read_words(FRAME_LEN, "t5_rd_over");
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick();
      check_val("t5_overread_hold", rd_data, 8'h0F);
    end
    rd_en = 1'b0;
    pulse_done();
    check_val("t5_occ_over", occupancy, 2'd0);

    // Reset during word 8 of a write and word 3 of a read
    write_frame(8'hC0, 1'b1);
    wait_start("t6_start", 4);
    for (int i = 0; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hD0 + DATA_W'(i);
      rd_en   = (i >= 5);
      if (i == 8) rst_n = 1'b0;
      tick();
      if (i >= 5 && i < 8) check_val("t6_rd_pre", rd_data, exp_q.pop_front());
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    check_val("t6_rst_start", frame_tx_start, 1'b0);
    check_val("t6_rst_ovf", overflow, 1'b0);
    check_val("t6_rst_rd_data", rd_data, 8'h00);
    check_val("t6_rst_occ", occupancy, 2'd0);
    check_val("t6_rst_drop_cnt", drop_cnt, 16'd0);
    rst_n = 1'b1;
    snap = start_cnt;
    repeat (10) tick();
    check_val("t6_no_stale_start", start_cnt, snap);
    write_frame(8'hE0, 1'b1);
    wait_start("t6_start_new", 4);
    read_words(FRAME_LEN, "t6_rd_new");
    pulse_done();
    check_val("t6_occ_end", occupancy, 2'd0);

    // ------------------------------------------------------------- report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
